// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD measurement sequencer and the SPGD update logic.
package spgd_pkg;

   localparam int ADC_WIDTH_DEF  = 12;
   localparam int TIME_WIDTH_DEF = 32;
   localparam int WD_MARGIN_DEF  = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETTLE_P,
      ST_AVG_P,
      ST_CAP_P,
      ST_CLEAR,
      ST_SETTLE_M,
      ST_AVG_M,
      ST_CAP_M,
      ST_REPORT
   } seq_state_t;

endpackage

// File: rtl/seq_timer.sv
// Clearable up-counter with an equality compare against a target value.
module seq_timer #(
   parameter int WIDTH = 33
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CLR,
   input  logic [WIDTH-1:0] TARGET,
   output logic             EQ
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge CLK) begin
      if (!RESETN || CLR)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign EQ = (count == TARGET);

endmodule

// File: rtl/spgd_measure_sequencer.sv
// Sequences one +delta / -delta metric measurement and reports delta_j = j_plus - j_minus.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for START, config latched on acceptance
// SETTLE_P  | +delta applied, waiting max(settle,1) cycles
// AVG_P     | averager running for +delta, watchdog armed
// CAP_P     | averager output valid, captured into J_PLUS
// CLEAR     | averager cleared for one cycle, sign switched to -delta
// SETTLE_M  | -delta applied, waiting max(settle,1) cycles
// AVG_M     | averager running for -delta, watchdog armed
// CAP_M     | averager output valid, captured into J_MINUS
// REPORT    | DELTA_J computed, RESULT_VALID pulsed on exit
module spgd_measure_sequencer
   import spgd_pkg::*;
#(
   parameter int ADC_WIDTH       = ADC_WIDTH_DEF,
   parameter int TIME_DATA_WIDTH = TIME_WIDTH_DEF,
   parameter int WD_MARGIN       = WD_MARGIN_DEF
) (
   input  logic                       CLK,
   input  logic                       RESETN,
   input  logic                       START,
   input  logic                       ABORT,
   input  logic [TIME_DATA_WIDTH-1:0] SETTLE_CYCLES,
   input  logic [TIME_DATA_WIDTH-1:0] AVG_CYCLES,
   output logic                       AVG_EN,
   output logic [TIME_DATA_WIDTH-1:0] AVG_TIME,
   input  logic                       AVG_DONE,
   input  logic [ADC_WIDTH-1:0]       AVG_DATA,
   output logic                       PERT_APPLY,
   output logic                       PERT_SIGN,
   output logic                       BUSY,
   output logic [ADC_WIDTH-1:0]       J_PLUS,
   output logic [ADC_WIDTH-1:0]       J_MINUS,
   output logic [ADC_WIDTH:0]         DELTA_J,
   output logic                       RESULT_VALID,
   output logic                       ERROR
);

   localparam int TW1 = TIME_DATA_WIDTH + 1;

   seq_state_t                 state, state_nxt;
   logic [TIME_DATA_WIDTH-1:0] settle_lat, avg_lat;
   logic [TW1-1:0]             settle_tgt, wd_limit, wd_tgt, tmr_tgt;
   logic                       tmr_clr, tmr_eq, wd_trip;

   // Timer compares against N-1 because it reads 0 on the first cycle of a state.
   assign settle_tgt = (settle_lat == '0) ? '0 : ({1'b0, settle_lat} - TW1'(1));
   assign wd_limit   = {1'b0, avg_lat} + TW1'(WD_MARGIN);
   assign wd_tgt     = (wd_limit == '0) ? '0 : (wd_limit - TW1'(1));
   assign tmr_tgt    = (state == ST_SETTLE_P || state == ST_SETTLE_M) ? settle_tgt : wd_tgt;
   assign tmr_clr    = (state == ST_IDLE) || (state_nxt != state);

   seq_timer #(.WIDTH(TW1)) u_timer (
      .CLK    (CLK),
      .RESETN (RESETN),
      .CLR    (tmr_clr),
      .TARGET (tmr_tgt),
      .EQ     (tmr_eq)
   );

   always_comb begin
      state_nxt = state;
      wd_trip   = 1'b0;
      AVG_EN    = 1'b0;
      case (state)
         ST_IDLE:     if (START) state_nxt = ST_SETTLE_P;
         ST_SETTLE_P: if (tmr_eq) state_nxt = ST_AVG_P;
         ST_AVG_P: begin
            AVG_EN = 1'b1;
            if (AVG_DONE) state_nxt = ST_CAP_P;
            else if (tmr_eq) begin
               state_nxt = ST_IDLE;
               wd_trip   = 1'b1;
            end
         end
         ST_CAP_P: begin
            AVG_EN    = 1'b1;
            state_nxt = ST_CLEAR;
         end
         ST_CLEAR:    state_nxt = ST_SETTLE_M;
         ST_SETTLE_M: if (tmr_eq) state_nxt = ST_AVG_M;
         ST_AVG_M: begin
            AVG_EN = 1'b1;
            if (AVG_DONE) state_nxt = ST_CAP_M;
            else if (tmr_eq) begin
               state_nxt = ST_IDLE;
               wd_trip   = 1'b1;
            end
         end
         ST_CAP_M: begin
            AVG_EN    = 1'b1;
            state_nxt = ST_REPORT;
         end
         ST_REPORT:   state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
      if (ABORT) begin
         state_nxt = ST_IDLE;
         wd_trip   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state        <= ST_IDLE;
         settle_lat   <= '0;
         avg_lat      <= '0;
         J_PLUS       <= '0;
         J_MINUS      <= '0;
         DELTA_J      <= '0;
         RESULT_VALID <= 1'b0;
         ERROR        <= 1'b0;
      end else begin
         state        <= state_nxt;
         RESULT_VALID <= 1'b0;
         ERROR        <= wd_trip;
         if (!ABORT) begin
            case (state)
               ST_IDLE: begin
                  if (START) begin
                     settle_lat <= SETTLE_CYCLES;
                     avg_lat    <= AVG_CYCLES;
                  end
               end
               ST_CAP_P:  J_PLUS  <= AVG_DATA;
               ST_CAP_M:  J_MINUS <= AVG_DATA;
               ST_REPORT: begin
                  DELTA_J      <= $signed({J_PLUS[ADC_WIDTH-1], J_PLUS})
                                - $signed({J_MINUS[ADC_WIDTH-1], J_MINUS});
                  RESULT_VALID <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign AVG_TIME   = avg_lat;
   assign BUSY       = (state != ST_IDLE);
   assign PERT_APPLY = (state != ST_IDLE);
   assign PERT_SIGN  = (state == ST_CLEAR) || (state == ST_SETTLE_M) || (state == ST_AVG_M)
                    || (state == ST_CAP_M) || (state == ST_REPORT);

endmodule

// File: tb/tb_spgd_measure_sequencer.sv
// Scoreboard bench for spgd_measure_sequencer with a behavioural averager model.
module tb_spgd_measure_sequencer;

   localparam int AW = 12;
   localparam int TW = 32;

   logic          CLK = 1'b0;
   logic          RESETN = 1'b0;
   logic          START = 1'b0;
   logic          ABORT = 1'b0;
   logic [TW-1:0] SETTLE_CYCLES = '0;
   logic [TW-1:0] AVG_CYCLES = '0;
   logic          AVG_DONE = 1'b0;
   logic [AW-1:0] AVG_DATA = '0;
   logic          AVG_EN, PERT_APPLY, PERT_SIGN, BUSY, RESULT_VALID, ERROR;
   logic [TW-1:0] AVG_TIME;
   logic [AW-1:0] J_PLUS, J_MINUS;
   logic [AW:0]   DELTA_J;

   spgd_measure_sequencer #(.ADC_WIDTH(AW), .TIME_DATA_WIDTH(TW), .WD_MARGIN(16)) dut (
      .CLK(CLK), .RESETN(RESETN), .START(START), .ABORT(ABORT),
      .SETTLE_CYCLES(SETTLE_CYCLES), .AVG_CYCLES(AVG_CYCLES),
      .AVG_EN(AVG_EN), .AVG_TIME(AVG_TIME), .AVG_DONE(AVG_DONE), .AVG_DATA(AVG_DATA),
      .PERT_APPLY(PERT_APPLY), .PERT_SIGN(PERT_SIGN), .BUSY(BUSY),
      .J_PLUS(J_PLUS), .J_MINUS(J_MINUS), .DELTA_J(DELTA_J),
      .RESULT_VALID(RESULT_VALID), .ERROR(ERROR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0, n_valid = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [AW-1:0] jp;
      logic [AW-1:0] jm;
      logic [AW:0]   dj;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   function automatic exp_t mk_exp(input logic [AW-1:0] vp, input logic [AW-1:0] vm);
      exp_t e;
      e.jp = vp;
      e.jm = vm;
      e.dj = 13'(int'($signed(vp)) - int'($signed(vm)));
      return e;
   endfunction

   // Averager model: DONE after AVG_TIME enabled cycles, data valid the cycle after DONE.
   logic          av_stall = 1'b0;
   logic [AW-1:0] av_p = '0, av_m = '0;
   int            av_cnt = 0;
   bit            av_fired = 1'b0;
   initial forever begin
      @(posedge CLK); #1;
      if (!AVG_EN) begin
         av_cnt = 0; av_fired = 1'b0; AVG_DONE = 1'b0; AVG_DATA = 12'h5A5;
      end else if (!av_fired) begin
         av_cnt++;
         if (!av_stall && av_cnt >= int'(AVG_TIME)) begin
            AVG_DONE = 1'b1; av_fired = 1'b1;
         end
      end else begin
         AVG_DONE = 1'b0;
         AVG_DATA = PERT_SIGN ? av_m : av_p;
      end
   end

   always @(negedge CLK) begin
      if (RESETN) begin
         if (RESULT_VALID) begin
            n_valid++;
            if (sb.size() == 0) chk("valid_unexpected", RESULT_VALID, 1'b0);
            else begin
               mon_e = sb.pop_front();
               chk("j_plus", J_PLUS, mon_e.jp);
               chk("j_minus", J_MINUS, mon_e.jm);
               chk("delta_j", DELTA_J, mon_e.dj);
            end
         end
         if (ERROR) n_err++;
      end
   end

   task automatic tick();
      @(posedge CLK); #2;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, BUSY, 0);
      chk({tag, "_avg_en"}, AVG_EN, 0);
      chk({tag, "_avg_time"}, AVG_TIME, 0);
      chk({tag, "_pert_apply"}, PERT_APPLY, 0);
      chk({tag, "_pert_sign"}, PERT_SIGN, 0);
      chk({tag, "_j_plus"}, J_PLUS, 0);
      chk({tag, "_j_minus"}, J_MINUS, 0);
      chk({tag, "_delta_j"}, DELTA_J, 0);
      chk({tag, "_result_valid"}, RESULT_VALID, 0);
      chk({tag, "_error"}, ERROR, 0);
   endtask

   task automatic run_seq(input int settle, input int avg, input logic [AW-1:0] vp,
                          input logic [AW-1:0] vm, input bit stall);
      int  t0, s_eff, rise1, rise2, err_cyc, gap;
      bit  prev_en, done;
      SETTLE_CYCLES = settle; AVG_CYCLES = avg;
      av_p = vp; av_m = vm; av_stall = stall;
      if (!stall) sb.push_back(mk_exp(vp, vm));
      START = 1'b1; tick(); START = 1'b0;
      t0 = cyc;
      chk("busy_after_start", BUSY, 1);
      chk("pert_apply_after_start", PERT_APPLY, 1);
      s_eff = (settle == 0) ? 1 : settle;
      rise1 = -1; rise2 = -1; err_cyc = -1; gap = 0; prev_en = AVG_EN; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (AVG_EN && !prev_en) begin
            if (rise1 < 0) begin
               rise1 = cyc;
               chk("sign_plus_half", PERT_SIGN, 0);
               chk("avg_time", AVG_TIME, avg);
            end else begin
               rise2 = cyc;
               chk("sign_minus_half", PERT_SIGN, 1);
            end
         end
         if (!AVG_EN && rise1 >= 0 && rise2 < 0 && BUSY) gap++;
         if (ERROR) err_cyc = cyc;
         prev_en = AVG_EN;
         if (!BUSY) done = 1'b1;
         else tick();
      end
      chk("seq_finished", done, 1);
      chk("settle_length", rise1, t0 + s_eff);
      if (stall) begin
         chk("wd_error_time", err_cyc, rise1 + avg + 16);
         chk("wd_pert_apply", PERT_APPLY, 0);
         chk("wd_avg_en", AVG_EN, 0);
      end else begin
         chk("avg_en_gap", gap >= 1, 1);
         chk("no_error", err_cyc, -1);
      end
   endtask

   initial begin
      int  k, idle, nv;
      bit  found;
      repeat (3) tick();
      chk_all_zero("reset");
      RESETN = 1'b1; tick();

      run_seq(4, 8, 12'd100, 12'hFEC, 1'b0);       // +100 / -20
      tick(); chk("valid_count_1", n_valid, 1);
      chk("valid_one_cycle", RESULT_VALID, 0);

      run_seq(3, 5, 12'h800, 12'h7FF, 1'b0);       // -2048 / +2047
      tick(); chk("valid_count_2", n_valid, 2);

      run_seq(2, 8, 12'h123, 12'h456, 1'b1);       // stalled averager
      tick();
      chk("wd_err_count", n_err, 1);
      chk("wd_error_one_cycle", ERROR, 0);
      chk("wd_no_valid", n_valid, 2);
      chk("wd_j_plus_held", J_PLUS, 12'h800);
      chk("wd_j_minus_held", J_MINUS, 12'h7FF);
      chk("wd_delta_held", DELTA_J, 13'h1001);

      // Abort during AVG_M on the same cycle as AVG_DONE.
      SETTLE_CYCLES = 2; AVG_CYCLES = 4; av_p = 12'h011; av_m = 12'h055; av_stall = 1'b0;
      START = 1'b1; tick(); START = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (PERT_SIGN && AVG_DONE) found = 1'b1;
      end
      chk("abort_done_seen", found, 1);
      ABORT = 1'b1; tick(); ABORT = 1'b0;
      chk("abort_busy", BUSY, 0);
      chk("abort_pert_apply", PERT_APPLY, 0);
      chk("abort_pert_sign", PERT_SIGN, 0);
      chk("abort_avg_en", AVG_EN, 0);
      repeat (3) tick();
      chk("abort_j_plus", J_PLUS, 12'h011);
      chk("abort_j_minus_held", J_MINUS, 12'h7FF);
      chk("abort_delta_held", DELTA_J, 13'h1001);
      chk("abort_no_valid", n_valid, 2);
      chk("abort_no_error", n_err, 1);

      // START held high: back-to-back measurements with one IDLE cycle between.
      SETTLE_CYCLES = 1; AVG_CYCLES = 3; av_p = 12'd7; av_m = 12'hFFD;
      sb.push_back(mk_exp(12'd7, 12'hFFD));
      sb.push_back(mk_exp(12'd7, 12'hFFD));
      START = 1'b1; tick();
      idle = 0; nv = 0;
      for (int i = 0; i < 400 && nv < 2; i++) begin
         tick();
         if (RESULT_VALID) nv++;
         if (!BUSY && nv == 1) idle++;
         if (nv == 2) START = 1'b0;
      end
      START = 1'b0;
      chk("held_start_two_results", nv, 2);
      chk("held_start_idle_cycles", idle, 1);
      tick(); tick();
      chk("held_start_valid_total", n_valid, 4);
      chk("held_start_stops", BUSY, 0);

      run_seq(0, 2, 12'h001, 12'h002, 1'b0);       // settle of zero acts as one
      tick();

      // Reset during SETTLE_M.
      SETTLE_CYCLES = 6; AVG_CYCLES = 2; av_p = 12'h0AA; av_m = 12'h0BB;
      START = 1'b1; tick(); START = 1'b0;
      k = 0;
      for (int i = 0; i < 200 && k < 3; i++) begin
         tick();
         if (PERT_SIGN && !AVG_EN && PERT_APPLY) k++;
      end
      chk("reset_mid_reached_settle_m", k, 3);
      RESETN = 1'b0; tick();
      chk_all_zero("reset_mid");
      RESETN = 1'b1; tick(); tick();

      chk("scoreboard_empty", sb.size(), 0);
      chk("valid_total", n_valid, 5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spgd_measure_sequencer.md
# spgd_measure_sequencer

Sequences one SPGD metric measurement: applies a +δ perturbation, waits a settle time, runs the ADC averager over a window, captures J+, then repeats with −δ to capture J−, and reports ΔJ = J+ − J−. Sits between the SPGD update logic (which issues START and consumes ΔJ) and the ADC averager (driven through AVG_EN/AVG_TIME, read back through AVG_DONE/AVG_DATA). Includes a watchdog against a stalled averager and a synchronous abort.

## Interface
- ADC_WIDTH, 12, width of averaged metric (two's complement)
- TIME_DATA_WIDTH, 32, width of settle/window/timer values
- WD_MARGIN, 16, extra cycles beyond AVG_CYCLES allowed before the watchdog trips
- CLK  in  1  single clock, all logic posedge
- RESETN  in  1  synchronous, active-low reset
- START  in  1  request a measurement; sampled in IDLE only
- ABORT  in  1  synchronous abort, any state
- SETTLE_CYCLES  in  TIME_DATA_WIDTH  settle wait after each perturbation change
- AVG_CYCLES  in  TIME_DATA_WIDTH  averaging window
- AVG_EN  out  1  averager enable; low clears it
- AVG_TIME  out  TIME_DATA_WIDTH  averager window value
- AVG_DONE  in  1  averager done
- AVG_DATA  in  ADC_WIDTH  averager result, signed
- PERT_APPLY  out  1  perturbation active
- PERT_SIGN  out  1  0 = +δ, 1 = −δ
- BUSY  out  1  high in every state except IDLE
- J_PLUS, J_MINUS  out  ADC_WIDTH  captured metrics
- DELTA_J  out  ADC_WIDTH+1  signed J_PLUS − J_MINUS
- RESULT_VALID  out  1  one-cycle pulse, new J_PLUS/J_MINUS/DELTA_J
- ERROR  out  1  one-cycle pulse, watchdog trip

## Operation
- States: IDLE, SETTLE_P, AVG_P, CAP_P, CLEAR, SETTLE_M, AVG_M, CAP_M, REPORT.
- IDLE: START=1 → latch SETTLE_CYCLES/AVG_CYCLES, clear timer, go to SETTLE_P. Latched values drive AVG_TIME for the whole sequence.
- SETTLE_P/SETTLE_M: PERT_APPLY=1, AVG_EN=0; stay max(SETTLE_CYCLES,1) cycles, then go to AVG_x with the timer cleared.
- AVG_P/AVG_M: AVG_EN=1; first cycle with AVG_DONE=1 → CAP_x. If the timer reaches AVG_CYCLES+WD_MARGIN first → IDLE, pulse ERROR, leave J/ΔJ unchanged.
- CAP_P/CAP_M: AVG_EN stays 1 (averager output registers one cycle after DONE); on this cycle capture AVG_DATA into J_PLUS (CAP_P) or J_MINUS (CAP_M). CAP_P → CLEAR; CAP_M → REPORT.
- CLEAR: AVG_EN=0, PERT_SIGN ← 1, one cycle, then SETTLE_M.
- REPORT: register DELTA_J = sext(J_PLUS) − sext(J_MINUS) (ADC_WIDTH+1 bits, no overflow possible), pulse RESULT_VALID, then IDLE.
- Leaving to IDLE: PERT_APPLY=0, PERT_SIGN=0, AVG_EN=0.
- ABORT=1: IDLE next cycle from any state, no RESULT_VALID, no ERROR, outputs J/ΔJ unchanged. ABORT beats START, AVG_DONE and watchdog in the same cycle.
- START while BUSY is ignored. AVG_DONE outside AVG_x is ignored.
- Timer is TIME_DATA_WIDTH+1 bits so AVG_CYCLES+WD_MARGIN never wraps.

## Timing
- Reset (RESETN=0 at an edge): state IDLE; every output 0, AVG_TIME 0; latched config 0. Reset mid-sequence behaves as ABORT plus clearing J_PLUS/J_MINUS/DELTA_J.
- START at edge n → BUSY, PERT_APPLY high from n+1; AVG_EN rises at n+1+S (S = max(SETTLE_CYCLES,1)).
- Averager DONE seen at edge d → capture at d+1; for − half, CLEAR at d+2, SETTLE_M from d+3.
- RESULT_VALID and the new DELTA_J appear together, one cycle after CAP_M; BUSY falls on that same edge (REPORT counts as BUSY).
- Earliest START acceptance after RESULT_VALID: next cycle.

## Structure
- spgd_pkg: state enum, default widths, WD_MARGIN default; shared with SPGD update logic.
- One sub-module: seq_timer, a clearable up-counter with a compare-equal output, used for the settle and watchdog counts.
- Averager instantiated outside; this block only drives/reads its ports.

## Test plan
- SETTLE=4, AVG=8, model averager returns +100 then −20 → J_PLUS=100, J_MINUS=−20, DELTA_J=+120, one RESULT_VALID, PERT_SIGN low then high, AVG_EN low ≥1 cycle between halves.
- Extremes: J+=−2048, J−=+2047 → DELTA_J=−4095 (13-bit), no wrap.
- Averager never asserts DONE, AVG=8, WD_MARGIN=16 → ERROR pulse 24 cycles after AVG_EN rise, IDLE, PERT_APPLY=0, old J values held.
- ABORT in AVG_M with AVG_DONE same cycle → IDLE next cycle, no capture, no RESULT_VALID.
- START held high through a whole sequence → exactly one measurement per IDLE visit; second starts the cycle after REPORT.
- SETTLE_CYCLES=0 → settle lasts 1 cycle; RESETN low mid-SETTLE_M → all outputs 0 next cycle.
